// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: types shared by the store buffer and its overlap matcher.
//   u64, strobe_t : 64-bit data word and 8-bit byte-enable
//   sb_entry_t    : one buffered store {addr, data, strobe}
//   sb_state_t    : drain FSM states
//   word_addr()   : clears address bits [2:0]
package store_buffer_pkg;

  typedef logic [63:0] u64;
  typedef logic [7:0]  strobe_t;

  typedef struct packed {
    u64      addr;
    u64      data;
    strobe_t strobe;
  } sb_entry_t;

  typedef enum logic {SB_IDLE, SB_REQ} sb_state_t;

  function automatic u64 word_addr(input u64 a);
    return a & ~u64'(7);
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// store_buffer_match: combinational load/store overlap check.
//   Each live entry (age k < count, age 0 = head) is compared against the load:
//   same 8-byte word and at least one common byte lane. The youngest hit wins.
// Ports:
//   ent_addr/ent_strobe [DEPTH]   entry storage, indexed by physical slot
//   ent_data [DEPTH]              (STORE_BUF_FWD_EN only) entry data
//   head, count                   FIFO occupancy
//   ld_addr, ld_strobe            load being checked
//   hit                           any live entry overlaps the load
//   hit_data, hit_strobe          (STORE_BUF_FWD_EN only) youngest hit entry
// Configuration macro: STORE_BUF_FWD_EN
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  u64             ent_addr   [DEPTH],
  input  strobe_t        ent_strobe [DEPTH],
`ifdef STORE_BUF_FWD_EN
  input  u64             ent_data   [DEPTH],
  output u64             hit_data,
  output strobe_t        hit_strobe,
`endif
  input  logic [PW-1:0]  head,
  input  logic [PW:0]    count,
  input  u64             ld_addr,
  input  strobe_t        ld_strobe,
  output logic           hit
);

  logic [DEPTH-1:0] age_hit;
  logic [PW-1:0]    age_idx [DEPTH];

  // Walk entries by age so "youngest" is simply the highest matching age.
  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    assign age_idx[k] = head + PW'(k);
    // OR-ing in the low bits compares only addr[63:3].
    assign age_hit[k] = ((PW+1)'(k) < count) &&
                        ((ent_addr[age_idx[k]] | u64'(7)) == (ld_addr | u64'(7))) &&
                        (|(ent_strobe[age_idx[k]] & ld_strobe));
  end

  assign hit = |age_hit;

`ifdef STORE_BUF_FWD_EN
  always_comb begin
    hit_data   = '0;
    hit_strobe = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_hit[k]) begin
        hit_data   = ent_data[age_idx[k]];
        hit_strobe = ent_strobe[age_idx[k]];
      end
    end
  end
`endif

endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of lane-aligned stores draining to the data bus.
// Ports:
//   clk, resetn                       clock; async active-low reset
//   st_valid/st_ready, st_addr/data/strobe   store enqueue handshake
//   ld_valid, ld_addr, ld_strobe      load presented for overlap check
//   ld_conflict                       load must stall
//   ld_fwd_valid, ld_fwd_data         forwarded data (STORE_BUF_FWD_EN only, else 0)
//   dreq_valid, dreq_addr/data/strobe bus write request for the head entry
//   dresp_ok                          one-cycle completion of the outstanding write
//   drain                             blocks new enqueues while high
//   sb_empty                          no entries and no outstanding request
// Configuration macro: STORE_BUF_FWD_EN (store-to-load forwarding)
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    st_valid,
  output logic    st_ready,
  input  u64      st_addr,
  input  u64      st_data,
  input  strobe_t st_strobe,
  input  logic    ld_valid,
  input  u64      ld_addr,
  input  strobe_t ld_strobe,
  output logic    ld_conflict,
  output logic    ld_fwd_valid,
  output u64      ld_fwd_data,
  output logic    dreq_valid,
  output u64      dreq_addr,
  output u64      dreq_data,
  output strobe_t dreq_strobe,
  input  logic    dresp_ok,
  input  logic    drain,
  output logic    sb_empty
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t     entries_q [DEPTH];
  sb_entry_t     entries_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  sb_state_t     state_q, state_d;
  logic          push, pop;

  // No pop bypass when full: a slot only frees up on the cycle after the pop.
  assign st_ready = (count_q != (PW+1)'(DEPTH)) && !drain;
  assign push     = st_valid && st_ready;
  assign pop      = (state_q == SB_REQ) && dresp_ok;
  assign sb_empty = (count_q == '0) && (state_q == SB_IDLE);

  // ---------------- FIFO storage and pointers ----------------
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (push) begin
      entries_d[tail_q] = '{addr: word_addr(st_addr), data: st_data, strobe: st_strobe};
      tail_d            = tail_q + PW'(1);
    end
    if (pop) head_d = head_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------- drain FSM ----------------
  // The head slot is never written while occupied, so dreq_* stay stable
  // for the whole REQ phase without extra holding registers.
  always_comb begin
    state_d     = state_q;
    dreq_valid  = 1'b0;
    dreq_addr   = '0;
    dreq_data   = '0;
    dreq_strobe = '0;
    case (state_q)
      SB_IDLE: if (count_q != '0) state_d = SB_REQ;
      SB_REQ: begin
        dreq_valid  = 1'b1;
        dreq_addr   = entries_q[head_q].addr;
        dreq_data   = entries_q[head_q].data;
        dreq_strobe = entries_q[head_q].strobe;
        // Staying in REQ when entries remain gives back-to-back requests.
        if (pop && count_d == '0) state_d = SB_IDLE;
      end
      default: state_d = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= SB_IDLE;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      state_q   <= state_d;
    end
  end

  // ---------------- load overlap ----------------
  u64      ent_addr   [DEPTH];
  strobe_t ent_strobe [DEPTH];
  logic    hit;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr[i]   = entries_q[i].addr;
      ent_strobe[i] = entries_q[i].strobe;
    end
  end

`ifdef STORE_BUF_FWD_EN
  u64      ent_data [DEPTH];
  u64      hit_data;
  strobe_t hit_strobe;
  logic    covers;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_data[i] = entries_q[i].data;
  end
`endif

  store_buffer_match #(.DEPTH(DEPTH)) u_match (
    .ent_addr   (ent_addr),
    .ent_strobe (ent_strobe),
`ifdef STORE_BUF_FWD_EN
    .ent_data   (ent_data),
    .hit_data   (hit_data),
    .hit_strobe (hit_strobe),
`endif
    .head       (head_q),
    .count      (count_q),
    .ld_addr    (ld_addr),
    .ld_strobe  (ld_strobe),
    .hit        (hit)
  );

`ifdef STORE_BUF_FWD_EN
  // Forward only when the youngest overlapping store supplies every byte read.
  assign covers       = (ld_strobe & ~hit_strobe) == '0;
  assign ld_fwd_valid = ld_valid && hit && covers;
  assign ld_fwd_data  = ld_fwd_valid ? hit_data : '0;
  assign ld_conflict  = ld_valid && hit && !covers;
`else
  assign ld_conflict  = ld_valid && hit;
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = '0;
`endif

  // A completion with nothing outstanding means the bus side is confused.
  a_resp_in_idle: assert property (@(posedge clk) disable iff (!resetn)
    dresp_ok |-> state_q == SB_REQ);

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic    clk, resetn;
  logic    st_valid, st_ready;
  u64      st_addr, st_data;
  strobe_t st_strobe;
  logic    ld_valid;
  u64      ld_addr;
  strobe_t ld_strobe;
  logic    ld_conflict, ld_fwd_valid;
  u64      ld_fwd_data;
  logic    dreq_valid;
  u64      dreq_addr, dreq_data;
  strobe_t dreq_strobe;
  logic    dresp_ok, drain, sb_empty;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_strobe(st_strobe),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_strobe(ld_strobe),
    .ld_conflict(ld_conflict), .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_data(dreq_data),
    .dreq_strobe(dreq_strobe), .dresp_ok(dresp_ok), .drain(drain), .sb_empty(sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: stores accepted but not yet acknowledged, oldest first.
  typedef struct {
    u64      addr;
    u64      data;
    strobe_t strobe;
  } ref_t;
  ref_t exp_q[$];
  bit   m_req;     // a bus write is outstanding

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      m_req = 1'b0;
    end else begin
      int   n;
      bit   er, pop, push, hit, cov;
      ref_t y;
      n  = exp_q.size();
      er = (n != DEPTH) && !drain;
      chk("st_ready",   st_ready,   er);
      chk("sb_empty",   sb_empty,   (n == 0) && !m_req);
      chk("dreq_valid", dreq_valid, m_req);
      if (m_req && n > 0) begin
        chk("dreq_addr",   dreq_addr,   exp_q[0].addr);
        chk("dreq_data",   dreq_data,   exp_q[0].data);
        chk("dreq_strobe", dreq_strobe, exp_q[0].strobe);
      end
      hit = 1'b0;
      y   = '{addr: 0, data: 0, strobe: 0};
      for (int i = n - 1; i >= 0; i--) begin
        if (!hit && (exp_q[i].addr >> 3) == (ld_addr >> 3) &&
            (exp_q[i].strobe & ld_strobe) != 0) begin
          hit = 1'b1;
          y   = exp_q[i];
        end
      end
`ifdef STORE_BUF_FWD_EN
      cov = hit && ((ld_strobe & ~y.strobe) == 0);
      chk("ld_conflict",  ld_conflict,  ld_valid && hit && !cov);
      chk("ld_fwd_valid", ld_fwd_valid, ld_valid && cov);
      if (ld_valid && cov) chk("ld_fwd_data", ld_fwd_data, y.data);
`else
      cov = 1'b0;
      chk("ld_conflict",  ld_conflict,  ld_valid && hit);
      chk("ld_fwd_valid", ld_fwd_valid, cov);
      chk("ld_fwd_data",  ld_fwd_data,  64'd0);
`endif
      pop   = m_req && dresp_ok;
      push  = st_valid && er;
      m_req = m_req ? (pop ? (n - int'(pop) + int'(push)) != 0 : 1'b1) : (n != 0);
      if (pop) void'(exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  bit      s_acc, s_dreq, s_ready, s_empty, s_conf, s_fv;
  u64      s_fd, s_addr;
  strobe_t s_strb;

  // One clock: sample at negedge, record an accepted store at the posedge,
  // return just after the edge so the caller can change inputs.
  task automatic step();
    @(negedge clk);
    s_acc   = st_valid && st_ready;
    s_dreq  = dreq_valid;
    s_ready = st_ready;
    s_empty = sb_empty;
    s_conf  = ld_conflict;
    s_fv    = ld_fwd_valid;
    s_fd    = ld_fwd_data;
    s_addr  = dreq_addr;
    s_strb  = dreq_strobe;
    @(posedge clk);
    if (s_acc && resetn)
      exp_q.push_back('{addr: st_addr & ~64'h7, data: st_data, strobe: st_strobe});
    #1;
  endtask

  task automatic push_one(input u64 a, input u64 d, input strobe_t s);
    st_valid = 1'b1; st_addr = a; st_data = d; st_strobe = s;
    for (int i = 0; i < 50; i++) begin
      step();
      if (s_acc) break;
    end
    chk("push_accept", s_acc, 1'b1);
    st_valid = 1'b0;
  endtask

  task automatic wait_dreq();
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_dreq) break;
    end
    chk("wait_dreq", s_dreq, 1'b1);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 200; i++) begin
      dresp_ok = dreq_valid;
      step();
      if (!s_dreq && s_empty) break;
    end
    dresp_ok = 1'b0;
    chk("drain_empty", s_empty, 1'b1);
  endtask

  function automatic u64 rnd_addr();
    return 64'h0000_0040_0000_0000 + u64'($urandom_range(0, 5)) * 8 + u64'($urandom_range(0, 7));
  endfunction

  initial begin
    resetn = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_strobe = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_strobe = '0; dresp_ok = 1'b0; drain = 1'b0;
    #12;
    chk("rst_dreq_valid", dreq_valid, 1'b0);
    chk("rst_dreq_addr",  dreq_addr,  64'd0);
    chk("rst_sb_empty",   sb_empty,   1'b1);
    chk("rst_st_ready",   st_ready,   1'b1);
    chk("rst_conflict",   ld_conflict, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // 1: single store, response three cycles into the request
    push_one(64'h8000_0010, 64'h11, 8'h01);
    wait_dreq();
    chk("t1_addr", s_addr, 64'h8000_0010);
    chk("t1_strb", s_strb, 8'h01);
    step();
    chk("t1_hold2", s_strb, 8'h01);
    dresp_ok = 1'b1;
    step();
    chk("t1_hold3", s_addr, 64'h8000_0010);
    dresp_ok = 1'b0;
    step();
    chk("t1_empty", s_empty, 1'b1);
    chk("t1_idle",  s_dreq,  1'b0);

    // 2: fill, fifth store waits for the first pop (no bypass on the pop cycle)
    for (int i = 0; i < 4; i++) push_one(64'h200 + 64'(i) * 8, 64'(i) + 64'hA0, 8'hff);
    st_valid = 1'b1; st_addr = 64'h220; st_data = 64'hA4; st_strobe = 8'h3c;
    step();
    chk("t2_full_ready", s_ready, 1'b0);
    chk("t2_full_acc",   s_acc,   1'b0);
    dresp_ok = 1'b1;
    step();
    chk("t2_pop_acc", s_acc, 1'b0);
    dresp_ok = 1'b0;
    step();
    chk("t2_after_pop_acc", s_acc, 1'b1);
    st_valid = 1'b0;
    drain_all();

    // 3: push and complete every cycle, requests back to back
    begin
      bit seen;
      seen = 1'b0;
      st_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
        st_addr = 64'h2000 + 64'(i) * 8; st_data = {$urandom, $urandom};
        st_strobe = 8'(1 << (i % 8));
        dresp_ok = dreq_valid;
        step();
        chk("t3_acc", s_acc, 1'b1);
        if (seen) chk("t3_no_bubble", s_dreq, 1'b1);
        if (s_dreq) seen = 1'b1;
      end
      st_valid = 1'b0;
      drain_all();
    end

    // 4: overlap detection and forwarding
    push_one(64'h100, 64'h1122_3344_5566_7788, 8'h0f);
    ld_valid = 1'b1; ld_addr = 64'h104; ld_strobe = 8'hf0;
    step();
    chk("t4_disjoint_conf", s_conf, 1'b0);
    chk("t4_disjoint_fv",   s_fv,   1'b0);
    ld_addr = 64'h100; ld_strobe = 8'h01;
    step();
`ifdef STORE_BUF_FWD_EN
    chk("t4_fwd_valid", s_fv,   1'b1);
    chk("t4_fwd_data",  s_fd,   64'h1122_3344_5566_7788);
    chk("t4_fwd_conf",  s_conf, 1'b0);
`else
    chk("t4_conf", s_conf, 1'b1);
    chk("t4_fv",   s_fv,   1'b0);
`endif
    push_one(64'h100, 64'hAAAA_BBBB_CCCC_DDDD, 8'hff);
    step();
`ifdef STORE_BUF_FWD_EN
    chk("t4_young_data", s_fd, 64'hAAAA_BBBB_CCCC_DDDD);
`else
    chk("t4_young_conf", s_conf, 1'b1);
`endif
    ld_valid = 1'b0;
    step();
    chk("t4_ldoff_conf", s_conf, 1'b0);
    drain_all();

    // 5: drain blocks enqueue while the buffer empties
    push_one(64'h300, 64'h5, 8'h0f);
    push_one(64'h308, 64'h6, 8'hf0);
    drain = 1'b1; st_valid = 1'b1; st_addr = 64'h310; st_data = 64'h7; st_strobe = 8'h01;
    step();
    chk("t5_ready", s_ready, 1'b0);
    drain_all();
    chk("t5_no_acc", s_acc, 1'b0);
    st_valid = 1'b0; drain = 1'b0;

    // 6: asynchronous reset with requests outstanding
    for (int i = 0; i < 3; i++) push_one(64'h400 + 64'(i) * 8, 64'(i), 8'hff);
    wait_dreq();
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_dreq_valid", dreq_valid, 1'b0);
    chk("t6_sb_empty",   sb_empty,   1'b1);
    chk("t6_dreq_addr",  dreq_addr,  64'd0);
    exp_q.delete();
    step();
    step();
    resetn = 1'b1;
    step();
    chk("t6_empty_after", s_empty, 1'b1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      st_valid  = $urandom_range(0, 1) == 1;
      st_addr   = rnd_addr();
      st_data   = {$urandom, $urandom};
      st_strobe = 8'($urandom_range(1, 255));
      ld_valid  = $urandom_range(0, 1) == 1;
      ld_addr   = rnd_addr();
      ld_strobe = 8'($urandom_range(0, 255));
      drain     = $urandom_range(0, 9) == 0;
      dresp_ok  = dreq_valid && ($urandom_range(0, 2) == 0);
      step();
    end
    st_valid = 1'b0; ld_valid = 1'b0; drain = 1'b0;
    drain_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
